// File: rtl/systolic_sequencer.sv
// Operand sequencer for an NxN output-stationary systolic array: buffers A/B, then drives skewed streams.
// Optional SYSTOLIC_SEQ_ERR_EN adds a sticky err_o for writes/starts dropped while busy.
module systolic_sequencer #(
  parameter int N        = 4,
  parameter int NUM_BITS = 8,
  parameter int PE_LAT   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           a_we_i,
  input  logic [$clog2(N)-1:0]           a_row_i,
  input  logic [$clog2(N)-1:0]           a_col_i,
  input  logic [NUM_BITS-1:0]            a_data_i,
  input  logic                           b_we_i,
  input  logic [$clog2(N)-1:0]           b_row_i,
  input  logic [$clog2(N)-1:0]           b_col_i,
  input  logic [NUM_BITS-1:0]            b_data_i,
  output logic [N-1:0][NUM_BITS-1:0]     north_o,
  output logic [N-1:0][NUM_BITS-1:0]     west_o,
  output logic                           array_clr_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           c_valid_o,
`ifdef SYSTOLIC_SEQ_ERR_EN
  output logic                           err_o,
`endif
  output logic [2:0]                     state_o
);

  localparam int IW = $clog2(N);
  localparam int PW = $clog2(2 * N);
  localparam int CW = $clog2(2 * N + PE_LAT);
  localparam logic [CW-1:0] FEED_LAST  = CW'(2 * N - 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N - 2 + PE_LAT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] phase, tap;
  logic [NUM_BITS-1:0] a_buf [N][N];
  logic [NUM_BITS-1:0] b_buf [N][N];
  logic [N-1:0][NUM_BITS-1:0] north_n, west_n;
  logic can_write;

  // Handshake: start_i is a request sampled on any edge where busy_o=0; done_o pulses once per
  // completed run and c_valid_o stays high until the next accepted start.
  assign can_write = (state == S_IDLE) || (state == S_DONE);
  assign state_o   = state;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
        end
      end
      S_CLEAR: begin
        state_n = S_FEED;
        cnt_n   = '0;
      end
      S_FEED: begin
        if (cnt == FEED_LAST) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_n = start_i ? S_CLEAR : S_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Taps are computed for the upcoming phase so the streams leave a register aligned with the state.
  always_comb begin
    north_n = '0;
    west_n  = '0;
    tap     = '0;
    phase   = cnt_n[PW-1:0];
    if (state_n == S_FEED) begin
      for (int j = 0; j < N; j++) begin
        tap = phase - PW'(j);
        if ((phase >= PW'(j)) && (tap < PW'(N))) begin
          north_n[j] = b_buf[tap[IW-1:0]][j];
          west_n[j]  = a_buf[j][tap[IW-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      north_o     <= '0;
      west_o      <= '0;
      array_clr_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      c_valid_o   <= 1'b0;
    end else begin
      north_o     <= north_n;
      west_o      <= west_n;
      array_clr_o <= (state_n == S_CLEAR);
      busy_o      <= (state_n == S_CLEAR) || (state_n == S_FEED) || (state_n == S_DRAIN);
      done_o      <= (state_n == S_DONE);
      if (state_n == S_CLEAR) begin
        c_valid_o <= 1'b0;
      end else if (state_n == S_DONE) begin
        c_valid_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else if (can_write) begin
      if (a_we_i) a_buf[a_row_i][a_col_i] <= a_data_i;
      if (b_we_i) b_buf[b_row_i][b_col_i] <= b_data_i;
    end
  end

`ifdef SYSTOLIC_SEQ_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else if (state_n == S_CLEAR && can_write) begin
      err_o <= 1'b0;
    end else if (busy_o && (start_i || a_we_i || b_we_i)) begin
      err_o <= 1'b1;
    end
  end
`endif

endmodule
